// File: rtl/traffic_light_fsm_if.sv
// Link between the light sequencer and the time-parameter store.
// The sequencer drives the parameter select; the store answers one cycle later.
interface traffic_light_fsm_if;
   logic [1:0] selector;
   logic [3:0] t_value;

   modport master (output selector, input t_value);
   modport slave  (input selector, output t_value);
endinterface

// File: rtl/traffic_light_fsm.sv
// Main/side intersection sequencer.
// Each light state selects a time parameter, waits for the store's registered
// answer, loads it into a 4-bit down-counter and steps on the 1 Hz tick.
//
// state     | meaning
// ----------+---------------------------------------------------------
// MAIN_GRN1 | main green, base time; side sensor sampled at expiry
// MAIN_GRN2 | main green, extended time if side traffic was seen
// MAIN_YEL  | main yellow; serves a pending walk next if there is one
// WALK      | both red, walk lamp lit
// SIDE_GRN  | side green, base time; sensor decides on extension
// SIDE_EXT  | side green, extension time
// SIDE_YEL  | side yellow, then back to main green
//
// phase     | meaning
// ----------+---------------------------------------------------------
// PH_SEL    | selector just registered, store is sampling it
// PH_LOAD   | t_value valid, timer loads at the end of this cycle
// PH_RUN    | timer counts down on one_hz_enable
module traffic_light_fsm (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       one_hz_enable,
   input  logic                       sensor,
   input  logic                       walk_request,
   input  logic                       reprogram,
   traffic_light_fsm_if.master        store,
   output logic [2:0]                 main_lights,
   output logic [2:0]                 side_lights,
   output logic                       walk_light,
   output logic [2:0]                 state_out
);

   localparam logic [1:0] BASE_SELECT = 2'b00;
   localparam logic [1:0] EXT_SELECT  = 2'b01;
   localparam logic [1:0] YEL_SELECT  = 2'b10;

   localparam logic [2:0] LT_RED = 3'b100;
   localparam logic [2:0] LT_YEL = 3'b010;
   localparam logic [2:0] LT_GRN = 3'b001;

   typedef enum logic [2:0] {
      MAIN_GRN1 = 3'd0,
      MAIN_GRN2 = 3'd1,
      MAIN_YEL  = 3'd2,
      WALK      = 3'd3,
      SIDE_GRN  = 3'd4,
      SIDE_EXT  = 3'd5,
      SIDE_YEL  = 3'd6
   } state_e;

   typedef enum logic [1:0] {
      PH_SEL  = 2'd0,
      PH_LOAD = 2'd1,
      PH_RUN  = 2'd2
   } phase_e;

   state_e      state_q, state_d;
   phase_e      phase_q, phase_d;
   logic [3:0]  timer_q, timer_d;
   logic        ext_flag_q, ext_flag_d;
   logic        walk_pending_q, walk_pending_d;
   logic [1:0]  selector_q, selector_d;
   logic [2:0]  main_q, main_d;
   logic [2:0]  side_q, side_d;
   logic        walk_q, walk_d;
   logic        enter;

   function automatic logic [1:0] sel_for(input state_e st, input logic ext);
      case (st)
         MAIN_GRN2:          sel_for = ext ? EXT_SELECT : BASE_SELECT;
         MAIN_YEL, SIDE_YEL: sel_for = YEL_SELECT;
         WALK, SIDE_EXT:     sel_for = EXT_SELECT;
         default:            sel_for = BASE_SELECT;
      endcase
   endfunction

   function automatic logic [2:0] main_for(input state_e st);
      case (st)
         MAIN_GRN1, MAIN_GRN2: main_for = LT_GRN;
         MAIN_YEL:             main_for = LT_YEL;
         default:              main_for = LT_RED;
      endcase
   endfunction

   function automatic logic [2:0] side_for(input state_e st);
      case (st)
         SIDE_GRN, SIDE_EXT: side_for = LT_GRN;
         SIDE_YEL:           side_for = LT_YEL;
         default:            side_for = LT_RED;
      endcase
   endfunction

   // Next-state, timer and output decode; outputs are recomputed only on state entry.
   always_comb begin
      state_d        = state_q;
      phase_d        = phase_q;
      timer_d        = timer_q;
      ext_flag_d     = ext_flag_q;
      walk_pending_d = walk_pending_q | walk_request;
      selector_d     = selector_q;
      main_d         = main_q;
      side_d         = side_q;
      walk_d         = walk_q;
      enter          = 1'b0;

      if (reprogram) begin
         state_d    = MAIN_GRN1;
         ext_flag_d = 1'b0;
         enter      = 1'b1;
      end else begin
         case (phase_q)
            PH_SEL:  phase_d = PH_LOAD;
            PH_LOAD: begin
               phase_d = PH_RUN;
               // A zero time would never expire; run it as one tick instead.
               timer_d = (store.t_value == 4'd0) ? 4'd1 : store.t_value;
            end
            PH_RUN: begin
               if (one_hz_enable) begin
                  if (timer_q == 4'd1) begin
                     enter = 1'b1;
                     case (state_q)
                        MAIN_GRN1: begin
                           state_d    = MAIN_GRN2;
                           ext_flag_d = sensor;
                        end
                        MAIN_GRN2: state_d = MAIN_YEL;
                        MAIN_YEL:  state_d = walk_pending_q ? WALK : SIDE_GRN;
                        WALK:      state_d = SIDE_GRN;
                        SIDE_GRN:  state_d = sensor ? SIDE_EXT : SIDE_YEL;
                        SIDE_EXT:  state_d = SIDE_YEL;
                        SIDE_YEL:  state_d = MAIN_GRN1;
                        default:   state_d = MAIN_GRN1;
                     endcase
                  end else if (timer_q != 4'd0) begin
                     timer_d = timer_q - 4'd1;
                  end
               end
            end
            default: phase_d = PH_SEL;
         endcase
      end

      if (enter) begin
         phase_d    = PH_SEL;
         timer_d    = 4'd0;
         selector_d = sel_for(state_d, ext_flag_d);
         main_d     = main_for(state_d);
         side_d     = side_for(state_d);
         walk_d     = (state_d == WALK);
         // A request arriving on the entry edge is kept for a later cycle.
         if (state_d == WALK) walk_pending_d = walk_request;
      end
   end

   // Sequencer state and registered light/select outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= MAIN_GRN1;
         phase_q        <= PH_SEL;
         timer_q        <= 4'd0;
         ext_flag_q     <= 1'b0;
         walk_pending_q <= 1'b0;
         selector_q     <= BASE_SELECT;
         main_q         <= LT_GRN;
         side_q         <= LT_RED;
         walk_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         phase_q        <= phase_d;
         timer_q        <= timer_d;
         ext_flag_q     <= ext_flag_d;
         walk_pending_q <= walk_pending_d;
         selector_q     <= selector_d;
         main_q         <= main_d;
         side_q         <= side_d;
         walk_q         <= walk_d;
      end
   end

   assign store.selector = selector_q;
   assign main_lights    = main_q;
   assign side_lights    = side_q;
   assign walk_light     = walk_q;
   assign state_out      = state_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for the intersection sequencer with a registered parameter-store model.
module tb_traffic_light_fsm;

   typedef struct {
      int st;
      int sel;
      int ticks;
      int ml;
      int sl;
      int wl;
   } visit_t;

   logic clk;
   logic reset;
   logic one_hz_enable;
   logic sensor;
   logic walk_request;
   logic reprogram;
   logic [2:0] main_lights;
   logic [2:0] side_lights;
   logic walk_light;
   logic [2:0] state_out;

   logic [3:0] tbl [4];
   int tick_per;
   int tick_cnt;
   int checks;
   int errors;

   visit_t got_q[$];
   visit_t exp_q[$];
   visit_t cur;
   bit new_entry;
   bit in_visit;
   int cyc;

   traffic_light_fsm_if bus ();

   traffic_light_fsm dut (
      .clk           (clk),
      .reset         (reset),
      .one_hz_enable (one_hz_enable),
      .sensor        (sensor),
      .walk_request  (walk_request),
      .reprogram     (reprogram),
      .store         (bus),
      .main_lights   (main_lights),
      .side_lights   (side_lights),
      .walk_light    (walk_light),
      .state_out     (state_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // parameter store: registered lookup, one cycle behind the selector
   always @(posedge clk) bus.t_value <= tbl[bus.selector];

   // 1 Hz stand-in: one tick every tick_per cycles, changed just after the edge
   initial begin
      one_hz_enable = 1'b0;
      tick_cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         tick_cnt++;
         one_hz_enable = ((tick_cnt % tick_per) == 0);
      end
   end

   // record each state visit: entry state/select/lights and ticks seen from cycle 2 on
   initial begin
      new_entry = 1'b1;
      in_visit = 1'b0;
      cyc = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            new_entry = 1'b1;
            in_visit = 1'b0;
         end else begin
            if (new_entry || (int'(state_out) != cur.st)) begin
               if (in_visit) got_q.push_back(cur);
               cur.st = int'(state_out);
               cur.sel = int'(bus.selector);
               cur.ml = int'(main_lights);
               cur.sl = int'(side_lights);
               cur.wl = int'(walk_light);
               cur.ticks = 0;
               cyc = 0;
               in_visit = 1'b1;
            end
            if (cyc >= 2 && one_hz_enable) cur.ticks++;
            cyc++;
            new_entry = reprogram;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int obs, input int exp_v);
      checks++;
      if (obs != exp_v) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   function automatic int exp_main(input int st);
      if (st <= 1) return 1;
      if (st == 2) return 2;
      return 4;
   endfunction

   function automatic int exp_side(input int st);
      if (st == 4 || st == 5) return 1;
      if (st == 6) return 2;
      return 4;
   endfunction

   task automatic add_exp(input int st, input int sel, input int ticks);
      visit_t v;
      v.st = st;
      v.sel = sel;
      v.ticks = ticks;
      v.ml = exp_main(st);
      v.sl = exp_side(st);
      v.wl = (st == 3) ? 1 : 0;
      exp_q.push_back(v);
   endtask

   task automatic check_visits(input string name, input int budget);
      int n = 0;
      while (got_q.size() < exp_q.size() && n < budget) begin
         @(posedge clk);
         n++;
      end
      chk($sformatf("%s_nvisits", name), (got_q.size() >= exp_q.size()) ? 1 : 0, 1);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_q.size()) begin
            chk($sformatf("%s_v%0d_state", name, i), got_q[i].st, exp_q[i].st);
            chk($sformatf("%s_v%0d_sel", name, i), got_q[i].sel, exp_q[i].sel);
            chk($sformatf("%s_v%0d_ticks", name, i), got_q[i].ticks, exp_q[i].ticks);
            chk($sformatf("%s_v%0d_main", name, i), got_q[i].ml, exp_q[i].ml);
            chk($sformatf("%s_v%0d_side", name, i), got_q[i].sl, exp_q[i].sl);
            chk($sformatf("%s_v%0d_walk", name, i), got_q[i].wl, exp_q[i].wl);
         end
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #2 reset = 1'b0;
      got_q.delete();
      exp_q.delete();
      repeat (2) @(posedge clk);
   endtask

   task automatic release_reset();
      @(posedge clk);
      #2 reset = 1'b1;
   endtask

   task automatic walk_pulse();
      repeat (3) @(posedge clk);
      #2 walk_request = 1'b1;
      @(posedge clk);
      #2 walk_request = 1'b0;
   endtask

   task automatic check_reset_outputs(input string name);
      chk($sformatf("%s_sel", name), int'(bus.selector), 0);
      chk($sformatf("%s_main", name), int'(main_lights), 1);
      chk($sformatf("%s_side", name), int'(side_lights), 4);
      chk($sformatf("%s_walk", name), int'(walk_light), 0);
      chk($sformatf("%s_state", name), int'(state_out), 0);
   endtask

   initial begin
      int n;
      int j;
      int rt;
      bit done;
      checks = 0;
      errors = 0;
      reset = 1'b1;
      sensor = 1'b0;
      walk_request = 1'b0;
      reprogram = 1'b0;
      tick_per = 2;
      tbl[0] = 4'd6;
      tbl[1] = 4'd3;
      tbl[2] = 4'd2;
      tbl[3] = 4'd0;

      // asynchronous reset before any clock edge
      #1 reset = 1'b0;
      #1 check_reset_outputs("rst");

      // defaults, no side traffic: 0,1,2,4,6,0
      release_reset();
      add_exp(0, 0, 6); add_exp(1, 0, 6); add_exp(2, 2, 2);
      add_exp(4, 0, 6); add_exp(6, 2, 2); add_exp(0, 0, 6);
      check_visits("dflt", 2000);

      // side traffic throughout: both extensions taken
      apply_reset();
      sensor = 1'b1;
      release_reset();
      add_exp(0, 0, 6); add_exp(1, 1, 3); add_exp(2, 2, 2);
      add_exp(4, 0, 6); add_exp(5, 1, 3); add_exp(6, 2, 2);
      check_visits("sens", 2000);

      // single-cycle walk request in MAIN_GRN1, served once
      apply_reset();
      sensor = 1'b0;
      release_reset();
      walk_pulse();
      add_exp(0, 0, 6); add_exp(1, 0, 6); add_exp(2, 2, 2); add_exp(3, 1, 3);
      add_exp(4, 0, 6); add_exp(6, 2, 2); add_exp(0, 0, 6); add_exp(1, 0, 6);
      add_exp(2, 2, 2); add_exp(4, 0, 6);
      check_visits("walk", 3000);

      // zero yellow time runs one tick; ticks every cycle also hit SEL/LOAD
      apply_reset();
      tbl[2] = 4'd0;
      tick_per = 1;
      release_reset();
      add_exp(0, 0, 6); add_exp(1, 0, 6); add_exp(2, 2, 1);
      add_exp(4, 0, 6); add_exp(6, 2, 1);
      check_visits("yel0", 2000);

      // reset asserted mid-SIDE_GRN, outputs checked before any clock edge
      apply_reset();
      tbl[2] = 4'd2;
      tick_per = 2;
      release_reset();
      n = 0;
      while (state_out != 3'd4 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      chk("mid_side_reached", int'(state_out), 4);
      repeat (3) @(posedge clk);
      #3 reset = 1'b0;
      #1 check_reset_outputs("mid_rst");

      // reprogram on the MAIN_YEL expiry cycle with a walk pending
      apply_reset();
      release_reset();
      walk_pulse();
      n = 0;
      while (state_out != 3'd2 && n < 2000) begin
         @(posedge clk);
         #2;
         n++;
      end
      j = 0;
      rt = 0;
      done = 1'b0;
      while (!done && n < 2000) begin
         if (j >= 2 && one_hz_enable) begin
            rt++;
            if (rt == 2) begin
               reprogram = 1'b1;
               done = 1'b1;
            end
         end
         @(posedge clk);
         #2;
         reprogram = 1'b0;
         j++;
         n++;
      end
      chk("rp_seen", int'(done), 1);
      chk("rp_state", int'(state_out), 0);
      chk("rp_sel", int'(bus.selector), 0);
      add_exp(0, 0, 6); add_exp(1, 0, 6); add_exp(2, 2, 2);
      add_exp(0, 0, 6); add_exp(1, 0, 6); add_exp(2, 2, 2);
      add_exp(3, 1, 3); add_exp(4, 0, 6);
      check_visits("rprg", 3000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
